piradspi_cmd_sched: RTL

Round-robin scheduler that shares the single PiRad SPI engine among NREQ command requesters. It accepts packed 72-bit SPI command words (the padded command word used by the SPI engine command FIFO) from each requester and issues exactly one command to the engine at a time. It waits for the engine's 16-bit response (magic/id) and routes that response back to the requester that issued the command. It sits between the per-client command ports (PS register bank, DMA sequencers) and the SPI engine command/response streams.

---
 rtl/piradspi_cmd_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/piradspi_cmd_sched.sv
// Round-robin scheduler sharing one SPI engine among NREQ command requesters; one command in flight.
// Latency: accept at N, engine command from N+1, response to requester at N+3 at best (4-cycle minimum).
// Backpressure: valid/data held until handshake; engine responses are back-pressured outside WAIT_RSP.
module piradspi_cmd_sched #(
    parameter int NREQ           = 4,
    parameter int CMD_WIDTH      = 72,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NREQ-1:0]           s_cmd_tvalid,
    output logic [NREQ-1:0]           s_cmd_tready,
    input  logic [NREQ*CMD_WIDTH-1:0] s_cmd_tdata,
    output logic                      m_cmd_tvalid,
    input  logic                      m_cmd_tready,
    output logic [CMD_WIDTH-1:0]      m_cmd_tdata,
    input  logic                      s_rsp_tvalid,
    output logic                      s_rsp_tready,
    input  logic [15:0]               s_rsp_tdata,
    output logic [NREQ-1:0]           m_rsp_tvalid,
    input  logic [NREQ-1:0]           m_rsp_tready,
    output logic [15:0]               m_rsp_tdata,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant,
    output logic                      err_timeout,
    output logic                      err_mismatch,
    output logic [7:0]                err_count
);

    localparam int          GW       = $clog2(NREQ);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAGIC    = 8'hAD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DELIVER
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic [15:0]           r_rsp;
    logic [15:0]           r_tmo_cnt;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic                  r_err_timeout;
    logic                  r_err_mismatch;
    logic [7:0]            r_err_count;

    logic [GW-1:0]         w_scan_idx [NREQ];
    logic                  w_sel_vld;
    logic [GW-1:0]         w_sel_idx;
    logic [CMD_WIDTH-1:0]  w_sel_word;
    logic [7:0]            w_id;
    logic                  w_accept;
    logic                  w_match;
    logic                  w_mismatch;
    logic                  w_timeout;
    logic [8:0]            w_err_sum;

    // The command id travels inside the latched word; no separate copy is needed.
    assign w_id     = r_cmd[63:56];
    assign w_accept = (r_state == S_IDLE) && w_sel_vld;

    // Rotating scan order: position k holds requester (last_grant + 1 + k) mod NREQ.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx[k] = GW'((int'(r_last_grant) + k + 1) % NREQ);
        end
    end

    // Pick the first valid requester in scan order; scanning backwards lets the lowest position win.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (s_cmd_tvalid[w_scan_idx[k]]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_scan_idx[k];
            end
        end
    end

    // Mux the selected requester's command word out of the packed input bus.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_idx == GW'(i)) begin
                w_sel_word = s_cmd_tdata[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs; a matching response beats a same-cycle timeout.
    always_comb begin
        w_state_nxt  = r_state;
        s_cmd_tready = '0;
        m_cmd_tvalid = 1'b0;
        s_rsp_tready = 1'b0;
        m_rsp_tvalid = '0;
        w_match      = 1'b0;
        w_mismatch   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_vld) begin
                    // Gated by reset so no requester sees a ready while the block is held in reset.
                    s_cmd_tready[w_sel_idx] = aresetn;
                    w_state_nxt             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_cmd_tvalid = 1'b1;
                if (m_cmd_tready) begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                s_rsp_tready = 1'b1;
                if (s_rsp_tvalid && (s_rsp_tdata == {MAGIC, w_id})) begin
                    w_match     = 1'b1;
                    w_state_nxt = S_DELIVER;
                end else begin
                    w_mismatch = s_rsp_tvalid;
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                m_rsp_tvalid[r_grant] = 1'b1;
                if (m_rsp_tready[r_grant]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A timeout and a dropped response can land in the same cycle, so up to two errors count at once.
    assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_timeout} + {8'd0, w_mismatch};

    // Datapath: command/response holding registers, grant tracking, timeout counter, error reporting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cmd          <= '0;
            r_rsp          <= '0;
            r_tmo_cnt      <= '0;
            r_grant        <= '0;
            r_last_grant   <= GW'(NREQ - 1);
            r_err_timeout  <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_err_count    <= '0;
        end else begin
            if (w_accept) begin
                r_cmd        <= w_sel_word;
                r_grant      <= w_sel_idx;
                r_last_grant <= w_sel_idx;
            end
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT_RSP) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (w_match) begin
                r_rsp <= s_rsp_tdata;
            end else if (w_timeout) begin
                r_rsp <= {8'h00, w_id};
            end
            r_err_timeout  <= w_timeout;
            r_err_mismatch <= w_mismatch;
            r_err_count    <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign m_cmd_tdata  = r_cmd;
    assign m_rsp_tdata  = r_rsp;
    assign busy         = (r_state != S_IDLE);
    assign grant        = r_grant;
    assign err_timeout  = r_err_timeout;
    assign err_mismatch = r_err_mismatch;
    assign err_count    = r_err_count;

endmodule
